// File: rtl/flt12_to_fixed_if.sv
// Handshake bundle for flt12_to_fixed: float12 in, signed fixed-point word out.
// The slave modport is the converter; the master modport is its environment.
interface flt12_to_fixed_if #(
  parameter int OUT_W = 16
);
  logic             valid_i;
  logic             ready_o;
  logic [11:0]      data_i;
  logic             valid_o;
  logic             ready_i;
  logic [OUT_W-1:0] data_o;
  logic             ovf_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, ovf_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, ovf_o
  );
endinterface

// File: rtl/flt12_to_fixed.sv
// float12 {sgn, exp[4:0] bias 15, man[5:0]} to saturating signed fixed point, 3-stage pipeline.
// Define FLT12_TO_FIXED_RELU_EN to clamp every negative input to zero.
module flt12_to_fixed #(
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  flt12_to_fixed_if.slave bus
);
  localparam logic [OUT_W:0] POS_MAX = {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W:0] NEG_MAX = {2'b01, {(OUT_W-1){1'b0}}};
  localparam int             SH_BIG  = OUT_W - 6;

  logic                    adv;
  logic                    v1_q, v2_q, v3_q;
  logic                    sgn1_q, sgn1_d, zero1_q, zero1_d;
  logic [6:0]              mag1_q, mag1_d;
  logic signed [6:0]       sh1_q, sh1_d;
  logic                    sgn2_q;
  logic                    big2_q, big2_d;
  logic [OUT_W:0]          mag2_q, mag2_d;
  logic [6:0]              nsh;
  logic [7:0]              rsh;
  logic [OUT_W-1:0]        data3_q, data3_d;
  logic                    ovf3_q, ovf3_d;

  assign adv         = ~v3_q | bus.ready_i;
  assign bus.ready_o = adv;
  assign bus.valid_o = v3_q;
  assign bus.data_o  = data3_q;
  assign bus.ovf_o   = ovf3_q;

  always_comb begin
    sgn1_d  = bus.data_i[11];
    mag1_d  = {1'b1, bus.data_i[5:0]};
    zero1_d = (bus.data_i[10:6] == '0);
    sh1_d   = 7'(int'(bus.data_i[10:6]) + FRAC_W - 21);
  end

  // Right shifts carry one extra LSB so the last bit shifted out becomes the round bit.
  always_comb begin
    mag2_d = '0;
    big2_d = 1'b0;
    nsh    = 7'(-sh1_q);
    rsh    = {mag1_q, 1'b0} >> nsh;
    if (zero1_q) begin
      mag2_d = '0;
    end else if (!sh1_q[6]) begin
      if (int'(sh1_q) >= SH_BIG) big2_d = 1'b1;
      else mag2_d = {{(OUT_W-6){1'b0}}, mag1_q} << sh1_q[5:0];
    end else if (nsh < 7'd8) begin
      mag2_d = (OUT_W+1)'(rsh[7:1]) + (OUT_W+1)'(rsh[0]);
    end
  end

  always_comb begin
    data3_d = '0;
    ovf3_d  = 1'b0;
    if (!sgn2_q) begin
      if (big2_q || mag2_q > POS_MAX) begin
        data3_d = POS_MAX[OUT_W-1:0];
        ovf3_d  = 1'b1;
      end else begin
        data3_d = mag2_q[OUT_W-1:0];
      end
    end else begin
`ifdef FLT12_TO_FIXED_RELU_EN
      data3_d = '0;
      ovf3_d  = 1'b0;
`else
      if (big2_q || mag2_q > NEG_MAX) begin
        data3_d = NEG_MAX[OUT_W-1:0];
        ovf3_d  = 1'b1;
      end else begin
        data3_d = -mag2_q[OUT_W-1:0];
      end
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      sgn1_q  <= 1'b0;
      zero1_q <= 1'b0;
      mag1_q  <= '0;
      sh1_q   <= '0;
      sgn2_q  <= 1'b0;
      big2_q  <= 1'b0;
      mag2_q  <= '0;
      data3_q <= '0;
      ovf3_q  <= 1'b0;
    end else if (adv) begin
      v1_q    <= bus.valid_i;
      v2_q    <= v1_q;
      v3_q    <= v2_q;
      sgn1_q  <= sgn1_d;
      zero1_q <= zero1_d;
      mag1_q  <= mag1_d;
      sh1_q   <= sh1_d;
      sgn2_q  <= sgn1_q;
      big2_q  <= big2_d;
      mag2_q  <= mag2_d;
      data3_q <= data3_d;
      ovf3_q  <= ovf3_d;
    end
  end
endmodule

// File: tb/tb_flt12_to_fixed.sv
// Directed bench for flt12_to_fixed at OUT_W=16, FRAC_W=8.
// Expected words are hand-computed; negative cases follow FLT12_TO_FIXED_RELU_EN.
module tb_flt12_to_fixed;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  flt12_to_fixed_if #(.OUT_W(16)) bus ();

  flt12_to_fixed #(.OUT_W(16), .FRAC_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

`ifdef FLT12_TO_FIXED_RELU_EN
  localparam logic [15:0] E_NEG2P5 = 16'h0000;
  localparam logic [15:0] E_NEG128 = 16'h0000;
  localparam logic [15:0] E_NEGBIG = 16'h0000;
  localparam logic        O_NEGBIG = 1'b0;
`else
  localparam logic [15:0] E_NEG2P5 = 16'hFD80;
  localparam logic [15:0] E_NEG128 = 16'h8000;
  localparam logic [15:0] E_NEGBIG = 16'h8000;
  localparam logic        O_NEGBIG = 1'b1;
`endif

  logic [11:0] bp_in  [6];
  logic [15:0] bp_exp [6];
  logic        bp_ovf [6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic [11:0] d,
                      input logic [15:0] ed, input logic eo);
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.data_i  = d;
    #1 check({tag, " ready_o"}, 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    @(negedge clk);
    check({tag, " early"}, 32'(bus.valid_o), 32'd0);
    @(negedge clk);
    check({tag, " valid_o"}, 32'(bus.valid_o), 32'd1);
    check({tag, " data_o"}, 32'(bus.data_o), 32'(ed));
    check({tag, " ovf_o"}, 32'(bus.ovf_o), 32'(eo));
  endtask

  initial begin
    int          in_idx, out_idx, stalls;
    logic        held_v;
    logic [15:0] held_d;

    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.ready_i = 1'b0;
    #1;
    check("rst valid_o", 32'(bus.valid_o), 32'd0);
    check("rst data_o", 32'(bus.data_o), 32'd0);
    check("rst ovf_o", 32'(bus.ovf_o), 32'd0);
    check("rst ready_o", 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.ready_i = 1'b1;

    send("one",     12'h3C0, 16'h0100, 1'b0);
    send("neg2p5",  12'hC10, E_NEG2P5, 1'b0);
    send("exp0",    12'h03F, 16'h0000, 1'b0);
    send("rnd75",   12'h1A0, 16'h0001, 1'b0);
    send("rnd50",   12'h180, 16'h0001, 1'b0);
    send("rnd25",   12'h140, 16'h0000, 1'b0);
    send("pos128",  12'h580, 16'h7FFF, 1'b1);
    send("neg128",  12'hD80, E_NEG128, 1'b0);
    send("posmax",  12'h7FF, 16'h7FFF, 1'b1);
    send("negmax",  12'hFFF, E_NEGBIG, O_NEGBIG);
    send("negexp0", 12'h83F, 16'h0000, 1'b0);

    // Streaming with a 4-cycle downstream stall
    bp_in[0] = 12'h3C0; bp_exp[0] = 16'h0100; bp_ovf[0] = 1'b0;
    bp_in[1] = 12'hC10; bp_exp[1] = E_NEG2P5; bp_ovf[1] = 1'b0;
    bp_in[2] = 12'h1A0; bp_exp[2] = 16'h0001; bp_ovf[2] = 1'b0;
    bp_in[3] = 12'h580; bp_exp[3] = 16'h7FFF; bp_ovf[3] = 1'b1;
    bp_in[4] = 12'h400; bp_exp[4] = 16'h0200; bp_ovf[4] = 1'b0;
    bp_in[5] = 12'hD80; bp_exp[5] = E_NEG128; bp_ovf[5] = 1'b0;
    in_idx = 0; out_idx = 0; stalls = 0; held_v = 1'b0; held_d = '0;
    for (int c = 0; c < 40 && out_idx < 6; c++) begin
      @(negedge clk);
      bus.ready_i = !(c >= 4 && c < 8);
      bus.valid_i = (in_idx < 6);
      bus.data_i  = (in_idx < 6) ? bp_in[in_idx] : 12'h000;
      #1;
      if (held_v) check("bp hold", 32'(bus.data_o), 32'(held_d));
      check("bp ready_o", 32'(bus.ready_o), 32'(!(bus.valid_o && !bus.ready_i)));
      if (!bus.ready_o) stalls++;
      if (bus.valid_o && bus.ready_i) begin
        check("bp data_o", 32'(bus.data_o), 32'(bp_exp[out_idx]));
        check("bp ovf_o", 32'(bus.ovf_o), 32'(bp_ovf[out_idx]));
        out_idx++;
      end
      held_v = bus.valid_o && !bus.ready_i;
      held_d = bus.data_o;
      if (bus.valid_i && bus.ready_o) in_idx++;
    end
    check("bp out count", 32'(out_idx), 32'd6);
    check("bp stall seen", 32'(stalls > 0), 32'd1);
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.ready_i = 1'b1;
    repeat (4) @(negedge clk);

    // Asynchronous reset with three words in flight
    bus.valid_i = 1'b1; bus.data_i = 12'h3C0;
    @(negedge clk); bus.data_i = 12'h400;
    @(negedge clk); bus.data_i = 12'h580;
    @(negedge clk); bus.valid_i = 1'b0; bus.data_i = '0;
    check("pre-rst valid_o", 32'(bus.valid_o), 32'd1);
    check("pre-rst data_o", 32'(bus.data_o), 32'h0100);
    #2 rst = 1'b1;
    #1;
    check("async rst valid_o", 32'(bus.valid_o), 32'd0);
    check("async rst data_o", 32'(bus.data_o), 32'd0);
    check("async rst ovf_o", 32'(bus.ovf_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post-rst stale", 32'(bus.valid_o), 32'd0);
    end
    send("after rst", 12'h400, 16'h0200, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/flt12_to_fixed.md
Name: flt12_to_fixed

Overview:
- Decoder for the 12-bit float format that the float adders produce: sign [11], exponent [10:6] with bias 15, mantissa [5:0] with a hidden leading 1.
- Converts each float to a signed two's-complement fixed-point word for the accumulator/output stage of the neural processor datapath.
- Three-stage pipeline with valid/ready handshake and saturation.

Parameters:
- OUT_W, 16, width of the signed fixed-point output; legal range 8..24.
- FRAC_W, 8, number of fractional bits in the output; 0 <= FRAC_W < OUT_W.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  input float valid.
- ready_o  output  1  block can accept data_i this cycle.
- data_i  input  12  float12 input {sgn, exp[4:0], man[5:0]}.
- valid_o  output  1  output word valid.
- ready_i  input  1  downstream accepts data_o this cycle.
- data_o  output  OUT_W  signed fixed-point result.
- ovf_o  output  1  saturation occurred for this word; qualified by valid_o.

Behaviour:
- Reset (async, rst_i=1): all stage valids = 0, valid_o = 0, data_o = 0, ovf_o = 0. Reset mid-operation discards every in-flight word. ready_o = 1 after reset.
- Pipeline enable: adv = ~v3 | ready_i.
  - ready_o = adv.
  - When adv=1, all three stages shift together: v1<=valid_i, v2<=v1, v3<=v2.
  - When adv=0, all stage registers hold.
  - Bubbles are not collapsed.
- Latency: 3 cycles from an accepted input to valid_o when ready_i is held high. Throughput is 1 word/cycle.
- Output hold: while valid_o=1 and ready_i=0, data_o and ovf_o stay stable.
- Stage 1 (unpack):
  - Register the sign and mag7 = {1, man}.
  - Compute the signed shift sh = exp - 15 + FRAC_W - 6, held as a 7-bit signed value.
  - Set a zero flag when exp == 0. There are no denormals: any exp==0 input decodes to 0 regardless of sign or mantissa.
  - exp == 31 is an ordinary exponent, not Inf/NaN.
- Stage 2 (shift/round), producing an unsigned magnitude of OUT_W+1 bits:
  - sh >= 0: magnitude = mag7 << sh. If sh >= OUT_W-6, set the big flag, meaning the magnitude is >= 2^OUT_W and no exact shift is needed.
  - sh < 0: magnitude = mag7 >> -sh, rounded half away from zero: add 1 if the last bit shifted out is 1.
  - sh <= -8: magnitude = 0.
  - Zero flag set: magnitude = 0.
- Stage 3 (sign/saturate):
  - Positive input: if big or magnitude > 2^(OUT_W-1)-1, then data_o = 2^(OUT_W-1)-1 and ovf_o=1. Otherwise data_o = magnitude.
  - Negative input: if big or magnitude > 2^(OUT_W-1), then data_o = -2^(OUT_W-1) and ovf_o=1. Otherwise data_o = -magnitude.
  - magnitude == 2^(OUT_W-1) on a negative input is exact: ovf_o=0.
  - Negative input with magnitude 0 gives data_o=0 (no negative zero).
- Simultaneous events: accept and output in the same cycle when v3=1 and ready_i=1. valid_i is ignored while ready_o=0. The upstream source must hold data_i until it is accepted.

Optional Feature:
- Macro: FLT12_TO_FIXED_RELU_EN.
- Defined: any input with sgn=1 produces data_o=0 and ovf_o=0. This is a ReLU clamp, applied in stage 3, with latency unchanged.
- Undefined: negative inputs convert as specified above.

Test Plan (defaults OUT_W=16, FRAC_W=8, ready_i=1):
- data_i=0x3C0 (1.0) -> after 3 cycles valid_o=1, data_o=0x0100, ovf_o=0.
- data_i=0xC10 (-2.5) -> data_o=0xFD80.
- data_i=0x03F (exp=0) -> data_o=0x0000.
- Rounding:
  - data_i=0x1A0 (0.75 LSB) -> data_o=0x0001.
  - data_i=0x180 (0.5 LSB) -> data_o=0x0001.
  - data_i=0x140 (0.25 LSB) -> data_o=0x0000.
- Saturation:
  - data_i=0x580 (+128) -> data_o=0x7FFF, ovf_o=1.
  - data_i=0xD80 (-128) -> data_o=0x8000, ovf_o=0.
  - data_i=0x7FF -> data_o=0x7FFF, ovf_o=1.
  - data_i=0xFFF -> data_o=0x8000, ovf_o=1.
- Backpressure and reset:
  - Stream 6 words, drop ready_i for 4 cycles mid-stream -> ready_o=0 while v3=1; data_o held stable; no loss or duplication; words emerge in order.
  - Assert rst_i asynchronously with words in flight -> valid_o=0 immediately; no stale outputs after release.
  - With FLT12_TO_FIXED_RELU_EN defined: 0xC10 -> data_o=0x0000.
